adc_scan_controller: RTL and testbench
======================================

# adc_scan_controller

Sequencer for the board's multiplexed 8-bit ADC (ADC0808-style: address, ALE, START, EOC, OE). On a scan request it converts channels 0..NUM_CH-1 in order. For each channel it drives the mux address, issues the start pulse, waits for end-of-conversion, strobes the output enable, and presents each sample with its channel tag. It sits between the top-level acquisition logic and the ADC pins, and takes over the address-stepping and output-enable duties as one state machine.

## Interface
- NUM_CH, 4: channels per scan, 1..8.
- DATA_W, 8: ADC data width.
- START_W, 2: ALE/START pulse width in cycles, ≥1.
- OE_W, 2: OE high time in cycles, ≥1; data captured on the last cycle.
- EOC_TIMEOUT, 1023: maximum cycles spent in the EOC wait states per channel.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- init  in  1  scan request, sampled only in IDLE.
- adc_eoc  in  1  ADC end-of-conversion, asynchronous.
- adc_data  in  DATA_W  ADC output bus.
- adc_add  out  3  mux address.
- adc_ale  out  1  address latch enable.
- adc_start  out  1  conversion start.
- adc_oe  out  1  ADC output enable.
- sample_data  out  DATA_W  last captured sample.
- sample_ch  out  3  channel of sample_data.
- sample_valid  out  1  one-cycle strobe for a new sample.
- busy  out  1  high from SETUP until return to IDLE.
- done  out  1  one-cycle strobe at scan end.
- err  out  1  timeout flag; set on abort, cleared on the next accepted init.

## Operation
- Reset: FSM goes to IDLE. All outputs and counters are 0, and the synchronizer is cleared. Reset mid-scan abandons the scan immediately, with no done pulse.
- adc_eoc passes through a 2-flop synchronizer. All uses below refer to the synchronized eoc_s.
- IDLE: if init=1, clear err and ch, then go to SETUP. If init stays held, scans run back to back. Any init outside IDLE is ignored.
- SETUP (1 cycle): adc_add=ch. Go to START.
- START (START_W cycles): adc_ale=adc_start=1 and adc_add stays stable. Go to WAIT_LO.
- WAIT_LO: wait for eoc_s=0, which confirms the conversion began. Go to WAIT_HI.
- WAIT_HI: wait for eoc_s=1. Go to READ.
- The timeout counter clears on entering WAIT_LO and increments in WAIT_LO/WAIT_HI. When it reaches EOC_TIMEOUT in either state, set err=1, pulse done, and go to IDLE; the remaining channels are skipped.
- READ (OE_W cycles): adc_oe=1. On the last READ cycle, load sample_data←adc_data and sample_ch←ch. Go to NEXT.
- NEXT (1 cycle): sample_valid=1.
  - If ch==NUM_CH-1: done=1, ch←0, go to IDLE.
  - Otherwise: ch←ch+1 and go to SETUP.
- Width rules: ch is 3-bit, with the wrap handled by the compare rather than overflow. The timeout counter is $clog2(EOC_TIMEOUT+1) bits and saturates at its compare value.
- adc_add holds ch in every state, and returns to 0 in IDLE after done.

## Timing
- Cycle 0: IDLE with init=1. Cycle 1: SETUP, busy=1. Cycles 2..1+START_W: ALE/START high.
- EOC response latency is the ADC latency plus 2 synchronizer cycles.
- Per-channel overhead excluding the EOC wait: 1 + START_W + OE_W + 1 cycles, plus 2 cycles of WAIT_LO/WAIT_HI minimum.
- sample_valid comes 1 cycle after the capturing edge. sample_data/sample_ch hold until the next capture.
- done and busy=0: done is high in the final NEXT (or the timeout) cycle, and busy drops the cycle after.
- eoc_s already high entering WAIT_LO: the FSM waits; it does not skip.

## Structure
- Package adc_ctrl_pkg holds:
  - the FSM state encoding (IDLE, SETUP, START, WAIT_LO, WAIT_HI, READ, NEXT),
  - ADC_ADDR_W=3,
  - the default timing constants.
- Sub-module adc_sync2: a 2-flop synchronizer with asynchronous active-low clear. It is instantiated for adc_eoc.

## Test plan
- Nominal scan, NUM_CH=4, ADC model with EOC low 8 cycles then high, data=0x10+ch → four sample_valid strobes, ch 0..3, data 0x10..0x13, then one done, err=0, adc_add=0.
- ALE/START check → high exactly START_W=2 cycles per channel, adc_add stable throughout. OE check → high OE_W=2 cycles per channel.
- EOC stuck high on ch 2 → err=1 and done after EOC_TIMEOUT cycles, no sample for ch 2/3, back to IDLE. Next init clears err.
- init pulsed while busy → ignored, scan finishes once. init held high → second scan starts the cycle after IDLE re-entry.
- RST_N low during WAIT_HI of ch 1 → all outputs 0 asynchronously, no done. After release, idle until init.
- NUM_CH=1 → single sample on ch 0, done in the same cycle as sample_valid.

Source files
------------

// File: rtl/adc_ctrl_pkg.sv
// Shared types and default timing for the multiplexed-ADC scan sequencer.
package adc_ctrl_pkg;

    localparam int ADC_ADDR_W          = 3;
    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_DATA_W          = 8;
    localparam int DEF_START_W         = 2;
    localparam int DEF_OE_W            = 2;
    localparam int DEF_EOC_TIMEOUT     = 1023;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_READ    = 3'd5,
        ST_NEXT    = 3'd6
    } state_e;

    // Larger of two pulse widths; sizes the shared phase down-counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_scan_controller_sync.sv
// Two-flop synchronizer with asynchronous clear, used for the ADC EOC line.
module adc_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/adc_scan_controller.sv
// Scan sequencer for an ADC0808-style converter: steps the mux address,
// pulses ALE/START, waits for EOC, strobes OE and hands each sample upstream.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for init; adc_add parked at 0
// ST_SETUP   | one cycle of address setup before the start pulse
// ST_START   | ALE/START high for START_W cycles
// ST_WAIT_LO | waiting for synchronized EOC to drop (conversion began)
// ST_WAIT_HI | waiting for synchronized EOC to rise (conversion done)
// ST_READ    | OE high for OE_W cycles, data captured on the last one
// ST_NEXT    | sample_valid; advance channel or finish the scan
module adc_scan_controller
    import adc_ctrl_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int START_W     = DEF_START_W,
    parameter int OE_W        = DEF_OE_W,
    parameter int EOC_TIMEOUT = DEF_EOC_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  init_i,
    input  logic                  adc_eoc_i,
    input  logic [DATA_W-1:0]     adc_data_i,
    output logic [ADC_ADDR_W-1:0] adc_add_o,
    output logic                  adc_ale_o,
    output logic                  adc_start_o,
    output logic                  adc_oe_o,
    output logic [DATA_W-1:0]     sample_data_o,
    output logic [ADC_ADDR_W-1:0] sample_ch_o,
    output logic                  sample_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int TMO_W = $clog2(EOC_TIMEOUT + 1);
    localparam int PH_W  = $clog2(max2(START_W, OE_W) + 1);

    state_e                state_q, state_d;
    logic [ADC_ADDR_W-1:0] ch_q, ch_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     smp_data_q, smp_data_d;
    logic [ADC_ADDR_W-1:0] smp_ch_q, smp_ch_d;

    logic eoc_s;
    logic tmo_hit;
    logic last_ch;

    adc_sync2 u_eoc_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (adc_eoc_i),
        .q_o     (eoc_s)
    );

    // Counter stops at the compare value, so tmo_hit stays asserted once reached.
    assign tmo_hit = (tmo_q == TMO_W'(EOC_TIMEOUT));
    assign last_ch = (ch_q == ADC_ADDR_W'(NUM_CH - 1));

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            ph_q       <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            smp_data_q <= '0;
            smp_ch_q   <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            ph_q       <= ph_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            smp_data_q <= smp_data_d;
            smp_ch_q   <= smp_ch_d;
        end
    end

    // Next-state logic and per-state pin strobes.
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        ph_d           = ph_q;
        tmo_d          = tmo_q;
        err_d          = err_q;
        smp_data_d     = smp_data_q;
        smp_ch_d       = smp_ch_q;
        adc_ale_o      = 1'b0;
        adc_start_o    = 1'b0;
        adc_oe_o       = 1'b0;
        sample_valid_o = 1'b0;
        done_o         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (init_i) begin
                    err_d   = 1'b0;
                    ch_d    = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ph_d    = PH_W'(START_W - 1);
                state_d = ST_START;
            end
            ST_START: begin
                adc_ale_o   = 1'b1;
                adc_start_o = 1'b1;
                if (ph_q == '0) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_LO;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            ST_WAIT_LO, ST_WAIT_HI: begin
                if (tmo_hit) begin
                    // Abort: skip remaining channels and report through err.
                    err_d   = 1'b1;
                    done_o  = 1'b1;
                    ch_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (state_q == ST_WAIT_LO && !eoc_s) begin
                        state_d = ST_WAIT_HI;
                    end else if (state_q == ST_WAIT_HI && eoc_s) begin
                        ph_d    = PH_W'(OE_W - 1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                adc_oe_o = 1'b1;
                if (ph_q == '0) begin
                    smp_data_d = adc_data_i;
                    smp_ch_d   = ch_q;
                    state_d    = ST_NEXT;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            ST_NEXT: begin
                sample_valid_o = 1'b1;
                if (last_ch) begin
                    done_o  = 1'b1;
                    ch_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + ADC_ADDR_W'(1);
                    state_d = ST_SETUP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign adc_add_o     = ch_q;
    assign sample_data_o = smp_data_q;
    assign sample_ch_o   = smp_ch_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_adc_scan_controller.sv
// Scoreboard bench for adc_scan_controller with a behavioural ADC model.
module tb_adc_scan_controller;

    localparam int NUM_CH      = 4;
    localparam int START_W     = 2;
    localparam int OE_W        = 2;
    localparam int EOC_TIMEOUT = 1023;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init;
    logic       adc_eoc;
    logic [7:0] adc_data;
    logic [2:0] adc_add;
    logic       adc_ale, adc_start, adc_oe;
    logic [7:0] sample_data;
    logic [2:0] sample_ch;
    logic       sample_valid, busy, done, err;

    logic       init1, eoc1;
    logic [7:0] data1;
    logic [2:0] add1, sch1;
    logic       ale1, start1, oe1, sval1, busy1, done1, err1;
    logic [7:0] sdata1;

    always #5 clk = ~clk;

    adc_scan_controller #(.NUM_CH(NUM_CH), .DATA_W(8), .START_W(START_W),
                          .OE_W(OE_W), .EOC_TIMEOUT(EOC_TIMEOUT)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .adc_eoc_i(adc_eoc),
        .adc_data_i(adc_data), .adc_add_o(adc_add), .adc_ale_o(adc_ale),
        .adc_start_o(adc_start), .adc_oe_o(adc_oe), .sample_data_o(sample_data),
        .sample_ch_o(sample_ch), .sample_valid_o(sample_valid), .busy_o(busy),
        .done_o(done), .err_o(err)
    );

    adc_scan_controller #(.NUM_CH(1), .DATA_W(8), .START_W(START_W),
                          .OE_W(OE_W), .EOC_TIMEOUT(EOC_TIMEOUT)) u_dut_1ch (
        .clk_i(clk), .rst_n_i(rst_n), .init_i(init1), .adc_eoc_i(eoc1),
        .adc_data_i(data1), .adc_add_o(add1), .adc_ale_o(ale1),
        .adc_start_o(start1), .adc_oe_o(oe1), .sample_data_o(sdata1),
        .sample_ch_o(sch1), .sample_valid_o(sval1), .busy_o(busy1),
        .done_o(done1), .err_o(err1)
    );

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;

    logic [10:0] exp_samp_q[$];
    bit          exp_done_q[$];

    // ADC model state
    logic [7:0] mem[8];
    int  stuck_ch = -1;
    bit  nom_mode = 1'b1;
    int  dly, lowc, lat_ch;
    bit  pend, conv_ok;

    assign adc_data = (adc_oe && conv_ok) ? mem[adc_add] : 8'h00;
    assign data1    = oe1 ? 8'hA5 : 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Converter: EOC drops a little after START ends, stays low, then rises with data ready.
    initial begin
        adc_eoc = 1'b1; pend = 0; dly = 0; lowc = 0; conv_ok = 0; lat_ch = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; dly = 0; lowc = 0; adc_eoc = 1'b1; conv_ok = 0;
            end else begin
                if (adc_start) begin
                    lat_ch = int'(adc_add); pend = 1; conv_ok = 0;
                end else if (pend) begin
                    pend = 0;
                    if (lat_ch != stuck_ch) begin
                        dly  = nom_mode ? 1 : int'($urandom_range(1, 4));
                        lowc = nom_mode ? 8 : int'($urandom_range(1, 10));
                    end
                end
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) adc_eoc = 1'b0;
                end else if (lowc > 0) begin
                    lowc--;
                    if (lowc == 0) begin
                        adc_eoc = 1'b1; conv_ok = 1;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations on sample_valid/done and checks pin pulse shapes.
    int   cyc = 0, fall_cyc = 0, ale_n = 0, oe_n = 0;
    bit   prev_done = 0, prev_err_exp = 0, prev_start = 0;
    logic [2:0]  ale_addr;
    logic [10:0] e;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_done = 0; ale_n = 0; oe_n = 0; prev_start = 0;
        end else begin
            if (prev_done) begin
                chk("busy_drop_after_done", busy, 0);
                chk("addr_zero_after_done", adc_add, 0);
                chk("err_after_done", err, prev_err_exp);
            end
            prev_done = 0;
            if (prev_start && !adc_start) fall_cyc = cyc;
            if (sample_valid) begin
                if (exp_samp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_sample: got ch %0d data %0h, required none", sample_ch, sample_data);
                end else begin
                    e = exp_samp_q.pop_front();
                    chk("sample_ch", sample_ch, e[10:8]);
                    chk("sample_data", sample_data, e[7:0]);
                end
            end
            if (done) begin
                done_cnt++;
                prev_done = 1;
                if (exp_done_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: got done=1, required 0 at %0t", $time);
                    prev_err_exp = err;
                end else begin
                    prev_err_exp = exp_done_q.pop_front();
                    if (!prev_err_exp) chk("done_with_last_valid", sample_valid, 1);
                    else chk("timeout_latency_in_range",
                             (cyc - fall_cyc >= EOC_TIMEOUT - 1) && (cyc - fall_cyc <= EOC_TIMEOUT + 1), 1);
                end
            end
            chk("ale_eq_start", adc_ale, adc_start);
            if (adc_ale) begin
                if (ale_n == 0) ale_addr = adc_add;
                else chk("addr_stable_in_start", adc_add, ale_addr);
                ale_n++;
            end else if (ale_n != 0) begin
                chk("ale_width", ale_n, START_W);
                ale_n = 0;
            end
            if (adc_oe) oe_n++;
            else if (oe_n != 0) begin
                chk("oe_width", oe_n, OE_W);
                oe_n = 0;
            end
            prev_start = adc_start;
        end
    end

    task automatic load_mem(input bit nominal);
        for (int c = 0; c < 8; c++)
            mem[c] = nominal ? 8'(8'h10 + c) : 8'($urandom_range(1, 255));
    endtask

    // Reference: channels 0..NUM_CH-1 in order, truncated at a stuck channel.
    task automatic push_scan(input int stuck);
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == stuck) break;
            exp_samp_q.push_back({3'(c), mem[c]});
        end
        exp_done_q.push_back(stuck >= 0);
    endtask

    task automatic wait_done(input string nm, input int limit);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < limit) begin
            tick();
            n++;
        end
        if (done_cnt == base) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: got no done in %0d cycles, required done", nm, limit);
        end
    endtask

    task automatic scan(input string nm, input int stuck, input bit nominal);
        load_mem(nominal);
        stuck_ch = stuck;
        nom_mode = nominal;
        push_scan(stuck);
        init = 1'b1;
        tick();
        init = 1'b0;
        chk({nm, "_busy_setup"}, busy, 1);
        chk({nm, "_err_cleared"}, err, 0);
        wait_done(nm, 3000);
        tick();
    endtask

    task automatic wait_sig(input string nm, input bit want, input int limit, input bit which);
        int n = 0;
        while (((which ? adc_start : adc_eoc) !== want) && n < limit) begin
            tick();
            n++;
        end
        if ((which ? adc_start : adc_eoc) !== want) begin
            n_chk++; n_fail++;
            $display("FAIL %s: got no level %0d in %0d cycles, required it", nm, want, limit);
        end
    endtask

    initial begin
        int base, n;
        rst_n = 1'b0; init = 1'b0; init1 = 1'b0; eoc1 = 1'b1;
        load_mem(1);
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_outputs", {adc_add, adc_ale, adc_start, adc_oe, sample_valid, done, err}, 0);
        chk("rst_sample", {sample_ch, sample_data}, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        scan("nominal", -1, 1);
        for (int i = 0; i < 3; i++) scan("random", -1, 0);

        scan("stuck_ch2", 2, 0);
        repeat (5) tick();
        chk("err_sticky", err, 1);
        chk("idle_after_abort", busy, 0);
        scan("after_abort", -1, 0);

        // init pulses while busy are ignored
        load_mem(0); stuck_ch = -1; nom_mode = 0; push_scan(-1);
        init = 1'b1; tick(); init = 1'b0;
        repeat (10) tick();
        init = 1'b1; repeat (3) tick(); init = 1'b0;
        wait_done("ignored_init", 3000);
        repeat (30) tick();
        chk("single_scan_then_idle", busy, 0);

        // init held: two scans back to back with one IDLE cycle between
        load_mem(0); push_scan(-1); push_scan(-1);
        init = 1'b1; tick();
        wait_done("held_first", 3000);
        tick();
        chk("held_idle_cycle", busy, 0);
        tick();
        chk("held_restart", busy, 1);
        init = 1'b0;
        wait_done("held_second", 3000);
        tick();

        // reset during WAIT_HI of channel 1
        load_mem(1); nom_mode = 1; push_scan(-1);
        init = 1'b1; tick(); init = 1'b0;
        n = 0;
        while (!(adc_start && adc_add == 3'd1) && n < 200) begin tick(); n++; end
        chk("reached_ch1_start", adc_start && adc_add == 3'd1, 1);
        wait_sig("ch1_start_end", 0, 20, 1);
        wait_sig("ch1_eoc_low", 0, 20, 0);
        repeat (4) tick();
        base = done_cnt;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        exp_samp_q.delete();
        exp_done_q.delete();
        chk("async_rst_busy", busy, 0);
        chk("async_rst_outputs", {adc_add, adc_ale, adc_start, adc_oe, sample_valid, done, err}, 0);
        chk("async_rst_sample", {sample_ch, sample_data}, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_after_reset", busy, 0);
        chk("no_done_after_reset", done_cnt, base);
        scan("post_reset", -1, 0);

        // single-channel instance: sample and done in the same cycle
        init1 = 1'b1; tick(); init1 = 1'b0;
        n = 0;
        while (!start1 && n < 20) begin tick(); n++; end
        while (start1 && n < 40) begin tick(); n++; end
        eoc1 = 1'b0; repeat (4) tick(); eoc1 = 1'b1;
        n = 0;
        while (!sval1 && n < 30) begin tick(); n++; end
        chk("one_ch_valid", sval1, 1);
        chk("one_ch_done_with_valid", done1, 1);
        chk("one_ch_sample_ch", sch1, 0);
        chk("one_ch_sample_data", sdata1, 8'hA5);
        tick();
        chk("one_ch_idle", busy1, 0);
        chk("one_ch_err", err1, 0);

        repeat (5) tick();
        chk("samples_all_seen", exp_samp_q.size(), 0);
        chk("dones_all_seen", exp_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
